// File: rtl/move_dispatcher.sv
// Feeds (parent board, move) pairs to move_executor and queues the resulting child boards,
// each tagged with its move index and last flag, in a credit-protected FWFT FIFO.
module move_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EXEC_LAT   = 1,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned BOARD_W    = 256,
  parameter int unsigned MOVE_W     = 12
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               board_nomoves_in,
  input  logic               board_valid_in,
  output logic               board_ready_out,
  input  logic [MOVE_W-1:0]  move_in,
  input  logic               move_last_in,
  input  logic               move_valid_in,
  output logic               move_ready_out,
  output logic [MOVE_W-1:0]  exec_move_out,
  output logic [BOARD_W-1:0] exec_board_out,
  output logic               exec_valid_out,
  input  logic [BOARD_W-1:0] exec_board_in,
  input  logic               exec_captured_in,
  input  logic               exec_valid_in,
  output logic [BOARD_W-1:0] child_board_out,
  output logic               child_captured_out,
  output logic [IDX_W-1:0]   child_idx_out,
  output logic               child_last_out,
  output logic               child_valid_out,
  input  logic               child_ready_in,
  output logic               done_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TAG_W = IDX_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BOARD_W-1:0] r_parent;
  logic               r_board_ready;
  logic               r_move_ready;
  logic               r_exec_valid;
  logic               r_done;
  logic [MOVE_W-1:0]  r_exec_move;
  logic [TAG_W-1:0]   r_exec_tag;
  logic [TAG_W-1:0]   r_tag_pipe [EXEC_LAT];
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_infl;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_infl_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CNT_W:0]     w_credit;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [BOARD_W-1:0] r_fifo_board [FIFO_DEPTH];
  logic               r_fifo_cap   [FIFO_DEPTH];
  logic [TAG_W-1:0]   r_fifo_tag   [FIFO_DEPTH];

  logic               w_board_acc;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [TAG_W-1:0]   w_head_tag;

  assign w_board_acc = (r_state == S_IDLE) && board_valid_in && r_board_ready;
  assign w_accept    = r_move_ready && move_valid_in;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign w_push      = exec_valid_in && (r_infl != '0);
  assign w_pop       = (r_count != '0) && child_ready_in;
  assign w_head_tag  = r_fifo_tag[r_rd_ptr];

  always_comb begin
    w_infl_nxt = r_infl;
    if (w_accept && !w_push)      w_infl_nxt = r_infl + CNT_W'(1);
    else if (!w_accept && w_push) w_infl_nxt = r_infl - CNT_W'(1);

    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);

    // Credit counts both queued children and those still inside the executor.
    w_credit = {1'b0, w_count_nxt} + {1'b0, w_infl_nxt};

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_board_acc) w_state_nxt = board_nomoves_in ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && move_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_infl == '0) && w_pop && w_head_tag[0]) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_parent      <= '0;
      r_board_ready <= 1'b1;
      r_move_ready  <= 1'b0;
      r_exec_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_exec_move   <= '0;
      r_exec_tag    <= '0;
      r_idx         <= '0;
      r_infl        <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      for (int unsigned i = 0; i < EXEC_LAT; i++) r_tag_pipe[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_board[i] <= '0;
        r_fifo_cap[i]   <= 1'b0;
        r_fifo_tag[i]   <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_board_ready <= (w_state_nxt == S_IDLE);
      r_move_ready  <= (w_state_nxt == S_RUN) && (w_credit < DEPTH_C);
      r_done        <= (w_state_nxt == S_DONE);
      r_exec_valid  <= w_accept;
      r_infl        <= w_infl_nxt;
      r_count       <= w_count_nxt;

      if (w_board_acc) begin
        r_parent <= board_in;
        r_idx    <= '0;
      end else if (w_accept) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_accept) begin
        r_exec_move <= move_in;
        r_exec_tag  <= {r_idx, move_last_in};
      end

      // Tag travels alongside the executor so it lines up with exec_valid_in.
      r_tag_pipe[0] <= r_exec_tag;
      for (int unsigned i = 1; i < EXEC_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];

      if (w_push) begin
        r_fifo_board[r_wr_ptr] <= exec_board_in;
        r_fifo_cap[r_wr_ptr]   <= exec_captured_in;
        r_fifo_tag[r_wr_ptr]   <= r_tag_pipe[EXEC_LAT-1];
        r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  assign board_ready_out    = r_board_ready;
  assign move_ready_out     = r_move_ready;
  assign exec_move_out      = r_exec_move;
  assign exec_board_out     = r_parent;
  assign exec_valid_out     = r_exec_valid;
  assign done_out           = r_done;
  assign child_valid_out    = (r_count != '0);
  assign child_board_out    = r_fifo_board[r_rd_ptr];
  assign child_captured_out = r_fifo_cap[r_rd_ptr];
  assign child_idx_out      = w_head_tag[TAG_W-1:1];
  assign child_last_out     = w_head_tag[0];

endmodule

// File: tb/tb_move_dispatcher.sv
// Scoreboard bench for move_dispatcher with a one-cycle executor stub (4-bit piece per square).
module tb_move_dispatcher;

  localparam int unsigned BW = 256;
  localparam int unsigned MW = 12;

  typedef struct packed {
    logic [BW-1:0] b;
    logic          cap;
    logic [7:0]    idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] board_in;
  logic          board_nomoves_in, board_valid_in, board_ready_out;
  logic [MW-1:0] move_in;
  logic          move_last_in, move_valid_in, move_ready_out;
  logic [MW-1:0] exec_move_out;
  logic [BW-1:0] exec_board_out;
  logic          exec_valid_out;
  logic [BW-1:0] exec_board_in = '0;
  logic          exec_captured_in = 1'b0;
  logic          exec_valid_in = 1'b0;
  logic [BW-1:0] child_board_out;
  logic          child_captured_out;
  logic [7:0]    child_idx_out;
  logic          child_last_out, child_valid_out, child_ready_in, done_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_pulses = 0, done_cyc = 0, lastpop_cyc = 0;
  int exec_seen = 0, child_seen = 0;
  int p0 = 0, accept_cyc = 0;
  exp_t exp_q[$];
  logic [BW-1:0] cur_parent;
  logic [7:0]    exp_idx;

  move_dispatcher #(.FIFO_DEPTH(2), .EXEC_LAT(1), .IDX_W(8), .BOARD_W(BW), .MOVE_W(MW)) dut (
    .clk_in(clk), .rst_in(rst),
    .board_in(board_in), .board_nomoves_in(board_nomoves_in),
    .board_valid_in(board_valid_in), .board_ready_out(board_ready_out),
    .move_in(move_in), .move_last_in(move_last_in),
    .move_valid_in(move_valid_in), .move_ready_out(move_ready_out),
    .exec_move_out(exec_move_out), .exec_board_out(exec_board_out), .exec_valid_out(exec_valid_out),
    .exec_board_in(exec_board_in), .exec_captured_in(exec_captured_in), .exec_valid_in(exec_valid_in),
    .child_board_out(child_board_out), .child_captured_out(child_captured_out),
    .child_idx_out(child_idx_out), .child_last_out(child_last_out),
    .child_valid_out(child_valid_out), .child_ready_in(child_ready_in),
    .done_out(done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] apply_mv(input logic [BW-1:0] b, input logic [MW-1:0] m);
    logic [BW-1:0] r;
    logic [3:0]    p;
    int f, t;
    r = b;
    f = int'(m[11:6]);
    t = int'(m[5:0]);
    p = r[f*4 +: 4];
    r[f*4 +: 4] = 4'h0;
    r[t*4 +: 4] = p;
    return r;
  endfunction

  function automatic logic is_cap(input logic [BW-1:0] b, input logic [MW-1:0] m);
    int t;
    t = int'(m[5:0]);
    return (b[t*4 +: 4] != 4'h0);
  endfunction

  function automatic logic [BW-1:0] start_pos();
    logic [BW-1:0] r;
    logic [3:0] back [8];
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    r = '0;
    for (int f = 0; f < 8; f++) begin
      r[(0*8+f)*4 +: 4] = back[f];
      r[(1*8+f)*4 +: 4] = 4'd1;
      r[(6*8+f)*4 +: 4] = 4'd9;
      r[(7*8+f)*4 +: 4] = back[f] + 4'd8;
    end
    return r;
  endfunction

  // Executor stub: fixed one-cycle latency, not reset (so stale returns can occur).
  always @(posedge clk) begin
    exec_valid_in    <= exec_valid_out;
    exec_board_in    <= apply_mv(exec_board_out, exec_move_out);
    exec_captured_in <= is_cap(exec_board_out, exec_move_out);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every consumer handshake.
  always @(negedge clk) begin
    exp_t e;
    if (done_out) begin done_pulses++; done_cyc = cyc; end
    if (exec_valid_out) exec_seen++;
    if (child_valid_out) child_seen++;
    if (child_valid_out && child_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_child", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chkb("child_board", child_board_out, e.b);
        chk("child_captured", int'(child_captured_out), int'(e.cap));
        chk("child_idx", int'(child_idx_out), int'(e.idx));
        chk("child_last", int'(child_last_out), int'(e.last));
        if (child_last_out) lastpop_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_board(input logic [BW-1:0] b, input logic nm);
    int g;
    board_in = b; board_nomoves_in = nm; board_valid_in = 1'b1;
    g = 0;
    while (!board_ready_out && g < 200) begin tick(); g++; end
    if (g >= 200) chk("board_ready_timeout", 1, 0);
    p0 = done_pulses;
    accept_cyc = cyc;
    tick();
    board_valid_in = 1'b0; board_nomoves_in = 1'b0;
    cur_parent = b;
    exp_idx = 8'd0;
  endtask

  task automatic drive_move(input logic [MW-1:0] m, input logic last, input logic cap);
    int g;
    exp_t e;
    move_in = m; move_last_in = last; move_valid_in = 1'b1;
    g = 0;
    while (!move_ready_out && g < 500) begin tick(); g++; end
    if (g >= 500) chk("move_ready_timeout", 1, 0);
    tick();
    e.b = apply_mv(cur_parent, m); e.cap = cap; e.idx = exp_idx; e.last = last;
    exp_q.push_back(e);
    exp_idx = exp_idx + 8'd1;
    move_valid_in = 1'b0; move_last_in = 1'b0;
  endtask

  task automatic wait_done(input logic had_children);
    int g;
    g = 0;
    while (done_pulses == p0 && g < 1000) begin tick(); g++; end
    repeat (3) tick();
    chk("done_pulse_count", done_pulses - p0, 1);
    if (had_children) begin
      chk("done_after_last_pop", done_cyc - lastpop_cyc, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
    end
    chk("board_ready_after_done", int'(board_ready_out), 1);
  endtask

  localparam logic [MW-1:0] MV_E2E4 = {6'd12, 6'd28};
  localparam logic [MW-1:0] MV_G1F3 = {6'd6,  6'd21};
  localparam logic [MW-1:0] MV_D2D4 = {6'd11, 6'd27};
  localparam logic [MW-1:0] MV_E4D5 = {6'd28, 6'd35};

  initial begin
    logic [BW-1:0] cap_board;
    int e0, c0;
    rst = 1'b1; board_in = '0; board_nomoves_in = 1'b0; board_valid_in = 1'b0;
    move_in = '0; move_last_in = 1'b0; move_valid_in = 1'b0; child_ready_in = 1'b0;
    repeat (3) tick();
    chk("rst_board_ready", int'(board_ready_out), 1);
    chk("rst_move_ready", int'(move_ready_out), 0);
    chk("rst_exec_valid", int'(exec_valid_out), 0);
    chk("rst_child_valid", int'(child_valid_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_child_idx", int'(child_idx_out), 0);
    chkb("rst_child_board", child_board_out, '0);
    chk("rst_exec_move", int'(exec_move_out), 0);
    rst = 1'b0;
    tick();

    // Three quiet moves from the start position, consumer always ready.
    child_ready_in = 1'b1;
    send_board(start_pos(), 1'b0);
    drive_move(MV_E2E4, 1'b0, 1'b0);
    drive_move(MV_G1F3, 1'b0, 1'b0);
    drive_move(MV_D2D4, 1'b1, 1'b0);
    wait_done(1'b1);

    // Consumer stalled: two-entry credit must block the third move.
    child_ready_in = 1'b0;
    send_board(start_pos(), 1'b0);
    drive_move(MV_E2E4, 1'b0, 1'b0);
    drive_move(MV_G1F3, 1'b0, 1'b0);
    chk("credit_block_now", int'(move_ready_out), 0);
    repeat (5) tick();
    chk("credit_block_held", int'(move_ready_out), 0);
    chk("stalled_head_valid", int'(child_valid_out), 1);
    chk("stalled_head_idx", int'(child_idx_out), 0);
    child_ready_in = 1'b1;
    drive_move(MV_D2D4, 1'b1, 1'b0);
    wait_done(1'b1);

    // Parent with no moves: nothing issued, nothing queued.
    e0 = exec_seen; c0 = child_seen;
    send_board(start_pos(), 1'b1);
    wait_done(1'b0);
    chk("nomoves_exec_valid", exec_seen - e0, 0);
    chk("nomoves_child_valid", child_seen - c0, 0);
    chk("nomoves_done_latency", int'((done_cyc - accept_cyc) inside {[1:2]}), 1);

    // Capture e4xd5 then a quiet knight move.
    cap_board = '0;
    cap_board[28*4 +: 4] = 4'd1;
    cap_board[35*4 +: 4] = 4'd9;
    cap_board[6*4 +: 4]  = 4'd2;
    send_board(cap_board, 1'b0);
    drive_move(MV_E4D5, 1'b0, 1'b1);
    drive_move(MV_G1F3, 1'b1, 1'b0);
    wait_done(1'b1);

    // Reset with two moves in flight: partial parent abandoned.
    child_ready_in = 1'b0;
    send_board(start_pos(), 1'b0);
    drive_move(MV_E2E4, 1'b0, 1'b0);
    drive_move(MV_G1F3, 1'b0, 1'b0);
    chk("inflight_before_reset", int'(exec_valid_out), 1);
    p0 = done_pulses; c0 = child_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    child_ready_in = 1'b1;
    repeat (6) tick();
    chk("post_rst_no_child", child_seen - c0, 0);
    chk("post_rst_board_ready", int'(board_ready_out), 1);
    chk("post_rst_move_ready", int'(move_ready_out), 0);
    chk("post_rst_no_done", done_pulses - p0, 0);

    // 258 moves: index wraps 255 -> 0 -> 1, last only on the final child.
    send_board(start_pos(), 1'b0);
    for (int i = 0; i < 258; i++) begin
      drive_move({6'(i % 16), 6'(16 + (i % 32))}, (i == 257) ? 1'b1 : 1'b0, 1'b0);
    end
    wait_done(1'b1);
    chk("wrap_final_idx", int'(exp_idx), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
